// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that frames byte streams from NUM_SRC sources as
// SYNC, index, payload, XOR checksum and issues them to a UART serializer.
module uart_frame_arbiter #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned MAX_LEN   = 64,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic [NUM_SRC-1:0]     src_valid_i,
  input  logic [8*NUM_SRC-1:0]   src_data_i,
  input  logic [NUM_SRC-1:0]     src_last_i,
  output logic [NUM_SRC-1:0]     src_ready_o,
  output logic [NUM_SRC-1:0]     grant_o,
  output logic                   tx_start_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_finish_i,
  output logic                   busy_o,
  output logic                   trunc_o
);

  localparam int unsigned        IDX_W    = $clog2(NUM_SRC);
  localparam logic [7:0]         MAX_CNT  = 8'(MAX_LEN);
  localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SRC - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARB,
    S_SYNC_ISS,
    S_SYNC_WAIT,
    S_ID_ISS,
    S_ID_WAIT,
    S_PAY_ISS,
    S_PAY_WAIT,
    S_CHK_ISS,
    S_CHK_WAIT
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   rr_q;
  logic [IDX_W-1:0]   gidx_q;
  logic [NUM_SRC-1:0] grant_q;
  logic [NUM_SRC-1:0] src_ready_q;
  logic               tx_start_q;
  logic [7:0]         tx_data_q;
  logic               busy_q;
  logic               trunc_q;
  logic [7:0]         cnt_q;
  logic [7:0]         chk_q;
  logic               last_q;
  logic [1:0]         wcnt_q;

  logic               found_c;
  logic [IDX_W-1:0]   win_c;
  logic               gvalid_c;
  logic               glast_c;
  logic [7:0]         gdata_c;
  logic               wait_done_c;

  // Round-robin search from rr_q; lowest rotated offset wins.
  always_comb begin
    int idx;
    found_c = 1'b0;
    win_c   = '0;
    idx     = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= int'(NUM_SRC)) idx = idx - int'(NUM_SRC);
      if (src_valid_i[IDX_W'(idx)]) begin
        found_c = 1'b1;
        win_c   = IDX_W'(idx);
      end
    end
  end

  assign gvalid_c = src_valid_i[gidx_q];
  assign glast_c  = src_last_i[gidx_q];
  assign gdata_c  = src_data_i[{gidx_q, 3'b000} +: 8];

  // tx_finish is stale on the tx_start cycle and the one after; look from the second cycle on.
  assign wait_done_c = (wcnt_q == 2'd2) && tx_finish_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      gidx_q      <= '0;
      grant_q     <= '0;
      src_ready_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      trunc_q     <= 1'b0;
      cnt_q       <= 8'h00;
      chk_q       <= 8'h00;
      last_q      <= 1'b0;
      wcnt_q      <= 2'd0;
    end else begin
      tx_start_q  <= 1'b0;
      src_ready_q <= '0;
      trunc_q     <= 1'b0;
      if (wcnt_q != 2'd2) wcnt_q <= wcnt_q + 2'd1;

      unique case (state_q)
        S_IDLE: begin
          if (en_i && (|src_valid_i)) begin
            state_q <= S_ARB;
            busy_q  <= 1'b1;
          end
        end
        S_ARB: begin
          cnt_q <= 8'h00;
          if (found_c) begin
            grant_q <= ONE_HOT0 << win_c;
            gidx_q  <= win_c;
            rr_q    <= (win_c == LAST_IDX) ? '0 : win_c + IDX_W'(1);
            state_q <= S_SYNC_ISS;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_SYNC_ISS: begin
          tx_data_q  <= SYNC_BYTE;
          tx_start_q <= 1'b1;
          wcnt_q     <= 2'd0;
          state_q    <= S_SYNC_WAIT;
        end
        S_SYNC_WAIT: begin
          if (wait_done_c) state_q <= S_ID_ISS;
        end
        S_ID_ISS: begin
          tx_data_q  <= 8'(gidx_q);
          chk_q      <= 8'(gidx_q);
          tx_start_q <= 1'b1;
          wcnt_q     <= 2'd0;
          state_q    <= S_ID_WAIT;
        end
        S_ID_WAIT: begin
          if (wait_done_c) state_q <= S_PAY_ISS;
        end
        S_PAY_ISS: begin
          // Ready, issue and capture share the cycle; the source pops on ready.
          if (gvalid_c) begin
            src_ready_q <= ONE_HOT0 << gidx_q;
            tx_data_q   <= gdata_c;
            tx_start_q  <= 1'b1;
            chk_q       <= chk_q ^ gdata_c;
            cnt_q       <= cnt_q + 8'd1;
            last_q      <= glast_c;
            wcnt_q      <= 2'd0;
            state_q     <= S_PAY_WAIT;
          end
        end
        S_PAY_WAIT: begin
          if (wait_done_c) begin
            if (last_q) begin
              state_q <= S_CHK_ISS;
            end else if (cnt_q == MAX_CNT) begin
              state_q <= S_CHK_ISS;
              trunc_q <= 1'b1;
            end else begin
              state_q <= S_PAY_ISS;
            end
          end
        end
        S_CHK_ISS: begin
          tx_data_q  <= chk_q;
          tx_start_q <= 1'b1;
          wcnt_q     <= 2'd0;
          state_q    <= S_CHK_WAIT;
        end
        S_CHK_WAIT: begin
          if (wait_done_c) begin
            grant_q <= '0;
            if (en_i && (|src_valid_i)) begin
              state_q <= S_ARB;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign src_ready_o = src_ready_q;
  assign grant_o     = grant_q;
  assign tx_start_o  = tx_start_q;
  assign tx_data_o   = tx_data_q;
  assign busy_o      = busy_q;
  assign trunc_o     = trunc_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench: queued source models, a countdown serializer model and
// hand-computed frame byte sequences.
module tb_uart_frame_arbiter;

  localparam int unsigned NS      = 4;
  localparam int unsigned SER_LEN = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [NS-1:0]     src_valid;
  logic [8*NS-1:0]   src_data;
  logic [NS-1:0]     src_last;
  logic [NS-1:0]     src_ready;
  logic [NS-1:0]     grant;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_finish;
  logic              busy;
  logic              trunc;

  always #5 clk = ~clk;

  uart_frame_arbiter #(.NUM_SRC(NS), .MAX_LEN(4), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .src_valid_i(src_valid),
    .src_data_i (src_data),
    .src_last_i (src_last),
    .src_ready_o(src_ready),
    .grant_o    (grant),
    .tx_start_o (tx_start),
    .tx_data_o  (tx_data),
    .tx_finish_i(tx_finish),
    .busy_o     (busy),
    .trunc_o    (trunc)
  );

  // Serializer: finish drops on the edge that samples tx_start, rises SER_LEN cycles later.
  int ser_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_finish <= 1'b1;
      ser_cnt   <= 0;
    end else if (tx_start) begin
      tx_finish <= 1'b0;
      ser_cnt   <= SER_LEN;
    end else if (ser_cnt != 0) begin
      ser_cnt <= ser_cnt - 1;
      if (ser_cnt == 1) tx_finish <= 1'b1;
    end
  end

  // Source models: byte FIFOs popped on src_ready.
  logic [7:0]    smem  [NS][16];
  logic          slast [NS][16];
  int            shead [NS];
  int            stail [NS];
  logic [NS-1:0] have = '0;
  logic [NS-1:0] hold = '0;
  assign src_valid = have & ~hold;

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (src_ready[i] && shead[i] < stail[i]) shead[i]++;
      have[i] = shead[i] < stail[i];
      src_data[i*8 +: 8] = have[i] ? smem[i][shead[i]] : 8'h00;
      src_last[i] = have[i] ? slast[i][shead[i]] : 1'b0;
    end
  end

  // Monitor
  logic [7:0]    rx [$];
  logic [NS-1:0] gq [$];
  logic [7:0]    exp_q [$];
  int trunc_cnt = 0;
  int trunc_at  = -1;
  int multi_rdy = 0;
  always @(negedge clk) begin
    if (trunc) begin
      trunc_cnt++;
      trunc_at = rx.size();
    end
    if (tx_start) begin
      rx.push_back(tx_data);
      gq.push_back(grant);
    end
    if ($countones(src_ready) > 1) multi_rdy++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_src(input int s, input logic [7:0] d, input logic l);
    smem[s][stail[s]]  = d;
    slast[s][stail[s]] = l;
    stail[s]++;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int c = 0;
    while (rx.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_rx_timeout"}, 32'(rx.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_ready(input string tag, input int s, input int budget);
    int c = 0;
    while (!src_ready[s] && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_ready_seen"}, 32'(src_ready[s]), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD, 32'(exp_q[i]));
    check({tag, "_len"}, 32'(rx.size()), 32'(exp_q.size()));
    rx.delete();
    gq.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'h00);
    check({tag, "_src_ready"}, 32'(src_ready), 32'h0);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_trunc"}, 32'(trunc), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst_n = 1'b1;

    // Single frame from source 1
    push_src(1, 8'h10, 1'b0);
    push_src(1, 8'h20, 1'b1);
    en = 1'b1;
    exp_q = '{8'hA5, 8'h01, 8'h10, 8'h20, 8'h31};
    wait_rx("t1", 5, 400);
    wait_idle("t1", 200);
    for (int i = 0; i < gq.size(); i++) check("t1_grant", 32'(gq[i]), 32'h2);
    check("t1_grant_idle", 32'(grant), 32'h0);
    check_frame("t1_byte");

    // Contention from rr=0, then verify rr=3 by source 3 beating source 0
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx.delete();
    gq.delete();
    push_src(0, 8'h11, 1'b1);
    push_src(2, 8'h22, 1'b0);
    push_src(2, 8'h33, 1'b1);
    exp_q = '{8'hA5, 8'h00, 8'h11, 8'h11, 8'hA5, 8'h02, 8'h22, 8'h33, 8'h13};
    wait_rx("t2", 9, 800);
    wait_idle("t2", 200);
    check_frame("t2_byte");
    push_src(0, 8'h44, 1'b1);
    push_src(3, 8'h55, 1'b1);
    exp_q = '{8'hA5, 8'h03, 8'h55, 8'h56, 8'hA5, 8'h00, 8'h44, 8'h44};
    wait_rx("t2b", 8, 800);
    wait_idle("t2b", 200);
    check_frame("t2b_byte");

    // Truncation at MAX_LEN=4
    trunc_cnt = 0;
    for (int b = 1; b <= 6; b++) push_src(3, 8'(b), (b == 6));
    exp_q = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07,
              8'hA5, 8'h03, 8'h05, 8'h06, 8'h00};
    wait_rx("t3", 12, 1500);
    wait_idle("t3", 200);
    check("t3_trunc_cnt", 32'(trunc_cnt), 32'd1);
    check("t3_trunc_at", 32'(trunc_at), 32'd6);
    check_frame("t3_byte");

    // Source stalls mid-payload for 500 cycles
    push_src(0, 8'h0A, 1'b0);
    push_src(0, 8'h0B, 1'b0);
    push_src(0, 8'h0C, 1'b1);
    wait_ready("t4", 0, 400);
    hold[0] = 1'b1;
    begin
      int viol = 0;
      repeat (500) begin
        @(negedge clk);
        if (tx_start || (src_ready != '0)) viol++;
      end
      check("t4_stall_quiet", 32'(viol), 32'd0);
    end
    check("t4_busy_stalled", 32'(busy), 32'd1);
    hold[0] = 1'b0;
    exp_q = '{8'hA5, 8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    wait_rx("t4", 6, 600);
    wait_idle("t4", 200);
    check_frame("t4_byte");

    // en dropped during payload: frame completes, no new grant
    push_src(1, 8'h61, 1'b0);
    push_src(1, 8'h62, 1'b1);
    push_src(2, 8'h70, 1'b1);
    wait_ready("t5", 1, 400);
    en = 1'b0;
    exp_q = '{8'hA5, 8'h01, 8'h61, 8'h62, 8'h02};
    wait_rx("t5", 5, 600);
    wait_idle("t5", 200);
    repeat (60) @(negedge clk);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_grant", 32'(grant), 32'h0);
    check("t5_pending", 32'(src_valid[2]), 32'd1);
    check_frame("t5_byte");

    // Reset during PAY WAIT abandons the frame
    en = 1'b1;
    wait_ready("t6", 2, 400);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    push_src(2, 8'h71, 1'b1);
    repeat (2) @(negedge clk);
    rx.delete();
    gq.delete();
    rst_n = 1'b1;
    exp_q = '{8'hA5, 8'h02, 8'h71, 8'h73};
    wait_rx("t6", 4, 600);
    wait_idle("t6", 200);
    check_frame("t6_byte");

    check("one_ready_max", 32'(multi_rdy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_arbiter.md
UART_FRAME_ARBITER -- requirements
Module: uart_frame_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of byte-stream requesters, range 2..8.
REQ-002 Parameter MAX_LEN, default 64: maximum payload bytes per frame, range 1..255.
REQ-003 Parameter SYNC_BYTE, default 8'hA5: first byte of every frame.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 en  input  1  1 = new frames may be granted; 0 = finish the current frame, then idle.
REQ-007 src_valid  input  NUM_SRC  per-source "payload byte available".
REQ-008 src_data  input  8*NUM_SRC  per-source payload byte; source i occupies bits [8i+7:8i].
REQ-009 src_last  input  NUM_SRC  per-source "this byte ends the frame"; qualified by src_valid.
REQ-010 src_ready  output  NUM_SRC  one-cycle byte-accept strobe; at most one bit high per cycle.
REQ-011 grant  output  NUM_SRC  one-hot owner of the current frame; all zero when idle.
REQ-012 tx_start  output  1  one-cycle byte-issue pulse to the serializer.
REQ-013 tx_data  output  8  byte for the serializer; stable from the tx_start cycle until the next tx_start.
REQ-014 tx_finish  input  1  serializer idle/done level: cleared on the edge that samples tx_start, set when the stop bit completes.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 trunc  output  1  one-cycle pulse when a frame is cut at MAX_LEN.

Function
REQ-017 The frame format SHALL be SYNC_BYTE, source index (8-bit, zero-extended), payload bytes, then checksum.
REQ-018 The checksum SHALL be the XOR of the index byte and all payload bytes sent.
REQ-019 The states SHALL be IDLE, ARB, SYNC, ID, PAY, CHK; each byte state SHALL have an ISSUE phase and a WAIT phase.
REQ-020 IDLE SHALL go to ARB when en=1 and any src_valid=1.
REQ-021 ARB SHALL take one cycle.
REQ-022 ARB SHALL perform round-robin arbitration: search starts at pointer rr and wraps modulo NUM_SRC; the first source with src_valid=1 wins.
REQ-023 In ARB, grant SHALL be set to the winner and rr SHALL be set to winner+1 mod NUM_SRC; rr resets to 0.
REQ-024 If no src_valid is high in ARB, the block SHALL return to IDLE with grant and rr unchanged.
REQ-025 ISSUE phase: the block SHALL load tx_data, pulse tx_start for exactly one cycle, and enter WAIT next cycle.
REQ-026 WAIT phase: the block SHALL advance when tx_finish=1, sampled no earlier than the second cycle after the tx_start pulse.
REQ-027 The gap between the tx_finish=1 cycle and the next tx_start SHALL be at most 1 cycle.
REQ-028 PAY ISSUE SHALL stall until src_valid of the granted source is 1.
REQ-029 PAY ISSUE SHALL then pulse src_ready, tx_start and capture src_data in the same cycle; no byte is accepted while in WAIT.
REQ-030 Payload byte counter: 8-bit; reset to 0 in ARB; incremented on each accepted byte.
REQ-031 After a byte's WAIT completes, the block SHALL go to CHK if that byte had src_last=1 or the counter equals MAX_LEN, otherwise back to PAY ISSUE.
REQ-032 trunc SHALL pulse when CHK is entered because the counter reached MAX_LEN with src_last=0; the source's remaining bytes form its next frame.
REQ-033 After CHK WAIT, the block SHALL go to ARB if en=1 and any src_valid=1, otherwise to IDLE.
REQ-034 On leaving CHK, grant SHALL clear, except when re-arbitration in ARB sets it again.
REQ-035 en=0 SHALL NOT abort a frame in progress; it only blocks IDLE->ARB and CHK->ARB.
REQ-036 src_valid or src_last changes of non-granted sources SHALL have no effect mid-frame.

Reset
REQ-037 While rst_n=0: state=IDLE, tx_start=0, tx_data=8'h00, src_ready=0, grant=0, busy=0, trunc=0, rr=0, counter=0, checksum=0.
REQ-038 Reset mid-frame SHALL abandon the frame immediately; the first frame after reset SHALL begin with SYNC_BYTE.

Verification
REQ-039 Single frame: src1 sends 8'h10, 8'h20 (last) -> serializer sees A5,01,10,20,31; 5 tx_start pulses; grant=0010 throughout.
REQ-040 Contention: src0 and src2 both valid at start, rr=0 -> src0 frame first, then src2 frame; rr=3 afterwards.
REQ-041 Truncation: MAX_LEN=4, src3 streams 6 bytes 01..06 with last on 06 -> frame A5,03,01..04,07 with trunc pulse; then frame A5,03,05,06,00.
REQ-042 Stall: granted source drops src_valid for 500 cycles mid-payload -> tx_start stays 0 and src_ready stays 0 for that time; frame bytes correct.
REQ-043 en=0 asserted during payload -> current frame completes with checksum; then IDLE, busy=0, no new grant despite pending src_valid.
REQ-044 rst_n pulsed low during PAY WAIT -> all outputs at reset values within the same cycle; next frame begins A5.
